md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 199 +++++++++++++++++++
 tb/tb_md_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit that owns the HI/LO register pair.
// Multiply-class ops take MUL_LAT cycles. Divides use a radix-2 restoring divider that takes WIDTH cycles.
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [3:0]       MUL_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;
  localparam logic [3:0] OP_MFHI  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic             done_q, done_d;

  logic               accept, mul_signed, div_signed, ge;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc, mul_res;
  logic [WIDTH-1:0]   shifted, diff, rem_step, quo_step, quo_fix, rem_fix;

  assign accept = start & ~cancel & (state_q == S_IDLE);

  // Signed div works on magnitudes; the most-negative value maps onto itself, which is still correct unsigned.
  assign a_mag = ((MUL_OP == OP_DIV) && A[WIDTH-1]) ? -A : A;
  assign b_mag = ((MUL_OP == OP_DIV) && B[WIDTH-1]) ? -B : B;

  assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign a_ext = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = a_ext * b_ext;
  assign acc   = {hi_q, lo_q};

  always_comb begin
    mul_res = prod;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase
  end

  // rem_q[WIDTH-1] set means the shifted partial remainder exceeds WIDTH bits, so it is always >= divisor.
  assign shifted  = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign ge       = rem_q[WIDTH-1] | (shifted >= dvsr_q);
  assign diff     = shifted - dvsr_q;
  assign rem_step = ge ? diff : shifted;
  assign quo_step = {quo_q[WIDTH-2:0], ge};

  assign div_signed = (op_q == OP_DIV);
  assign quo_fix = (div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_step : quo_step;
  assign rem_fix = (div_signed && a_q[WIDTH-1]) ? -rem_step : rem_step;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (MUL_OP)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              state_d = S_MUL;
              op_d    = MUL_OP;
              a_d     = A;
              b_d     = B;
              cnt_d   = '0;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              op_d    = MUL_OP;
              a_d     = A;
              b_d     = B;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = a_mag;
              dvsr_d  = b_mag;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          state_d = S_IDLE;
          hi_d    = mul_res[2*WIDTH-1:WIDTH];
          lo_d    = mul_res[WIDTH-1:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          if (cnt_q == DIV_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (b_q == '0) begin
              lo_d = '1;
              hi_d = a_q;
            end else begin
              lo_d = quo_fix;
              hi_d = rem_fix;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign out  = (MUL_OP == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven, hand-sequenced and randomized checks of md_unit
// against an arithmetic reference model of HI/LO.
module tb_md_unit;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 5;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;
  localparam logic [3:0] OP_MFHI  = 4'd10;
  localparam logic [3:0] OP_MFLO  = 4'd11;

  logic        clk, reset, start, cancel;
  logic [3:0]  MUL_OP;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] out, hi, lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  md_unit #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel),
    .MUL_OP(MUL_OP), .A(A), .B(B),
    .busy(busy), .done(done), .out(out), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic int refLatency(input logic [3:0] op);
    if (op == OP_DIV || op == OP_DIVU) return WIDTH;
    if (op <= 4'd7) return MUL_LAT;
    return 0;
  endfunction

  // Reference behaviour: 64-bit integer arithmetic on the architectural HI/LO pair.
  task automatic refExec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, ps, pu, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ps  = 64'(sa * sb);
    pu  = ua * ub;
    acc = {m_hi, m_lo};
    case (op)
      4'd0: {m_hi, m_lo} = ps;
      4'd1: {m_hi, m_lo} = pu;
      4'd4: {m_hi, m_lo} = acc + ps;
      4'd5: {m_hi, m_lo} = acc + pu;
      4'd6: {m_hi, m_lo} = acc - ps;
      4'd7: {m_hi, m_lo} = acc - pu;
      4'd2, 4'd3: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (op == 4'd2) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = 32'(ua / ub);
          m_hi = 32'(ua % ub);
        end
      end
      4'd8: m_hi = a;
      4'd9: m_lo = a;
      default: ;
    endcase
  endtask

  // Drive one issue at the current negedge; returns at the next negedge with start released.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MUL_OP = op;
    A      = a;
    B      = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic waitIdle(input bit scramble, output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (scramble) begin
        A      = $urandom;
        B      = $urandom;
        MUL_OP = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit scramble, output int n);
    applyStimulus(op, a, b);
    refExec(op, a, b);
    waitIdle(scramble, n);
    checkOutput({name, " busy cycles"}, 32'(n), 32'(refLatency(op)));
    checkOutput({name, " done"}, {31'd0, done}, (refLatency(op) > 0) ? 32'd1 : 32'd0);
    checkOutput({name, " hi"}, hi, m_hi);
    checkOutput({name, " lo"}, lo, m_lo);
    MUL_OP = OP_MFHI;
    #1 checkOutput({name, " out mfhi"}, out, m_hi);
    MUL_OP = OP_MFLO;
    #1 checkOutput({name, " out mflo"}, out, m_lo);
  endtask

  initial begin
    int  n;
    bit  saw_done, saw_busy;
    logic [3:0]  op;
    logic [31:0] a, b;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, WIDTH};
    vecs[3]  = '{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, WIDTH};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, WIDTH};
    vecs[5]  = '{OP_MTHI,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 0};
    vecs[6]  = '{OP_MTLO,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0};
    vecs[7]  = '{OP_MADD,  32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, MUL_LAT};
    vecs[8]  = '{OP_MSUBU, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, MUL_LAT};
    vecs[9]  = '{OP_MFHI,  32'h0000_0123, 32'h0000_0456, 32'h0000_0000, 32'hFFFF_FFFF, 0};
    vecs[10] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, WIDTH};
    vecs[11] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, WIDTH};
    vecs[12] = '{4'd15,    32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0001, 32'hFFFF_FFFD, 0};

    reset  = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    MUL_OP = 4'd0;
    A      = 32'd0;
    B      = 32'd0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;

    repeat (2) @(negedge clk);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);

    // First edge after release must accept.
    reset = 1'b1;
    runOp("first-edge mtlo", OP_MTLO, 32'hA5A5_0001, 32'd0, 1'b0, n);

    $display("[TB] table vectors");
    for (int i = 0; i < 13; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, n);
      checkOutput($sformatf("vec%0d table latency", i), 32'(n), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d table hi", i), hi, vecs[i].exp_hi);
      checkOutput($sformatf("vec%0d table lo", i), lo, vecs[i].exp_lo);
    end

    $display("[TB] done pulse width");
    runOp("mult 3x4", OP_MULT, 32'd3, 32'd4, 1'b0, n);
    @(negedge clk);
    checkOutput("done one cycle", {31'd0, done}, 32'd0);

    $display("[TB] start while busy is ignored");
    applyStimulus(OP_MULT, 32'd6, 32'd7);
    refExec(OP_MULT, 32'd6, 32'd7);
    MUL_OP = OP_MTHI;
    A      = 32'hDEAD_BEEF;
    B      = 32'd99;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle(1'b0, n);
    checkOutput("ignored start busy cycles", 32'(n + 1), 32'(MUL_LAT));
    checkOutput("ignored start hi", hi, m_hi);
    checkOutput("ignored start lo", lo, 32'd42);

    $display("[TB] cancel on busy cycle 3");
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel busy", {31'd0, busy}, 32'd0);
    checkOutput("cancel done", {31'd0, done}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checkOutput("cancel no late done", {31'd0, saw_done}, 32'd0);
    checkOutput("cancel hi", hi, m_hi);
    checkOutput("cancel lo", lo, m_lo);

    $display("[TB] cancel on commit edge");
    applyStimulus(OP_MULT, 32'd5, 32'd5);
    repeat (MUL_LAT - 1) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("commit cancel busy", {31'd0, busy}, 32'd0);
    checkOutput("commit cancel done", {31'd0, done}, 32'd0);
    checkOutput("commit cancel hi", hi, m_hi);
    checkOutput("commit cancel lo", lo, m_lo);

    $display("[TB] cancel with start");
    MUL_OP = OP_MTLO;
    A      = 32'h1234_5678;
    start  = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    checkOutput("idle cancel+start lo", lo, m_lo);
    checkOutput("idle cancel+start busy", {31'd0, busy}, 32'd0);
    applyStimulus(OP_DIVU, 32'd50, 32'd3);
    MUL_OP = OP_MTHI;
    A      = 32'h0BAD_0BAD;
    start  = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    checkOutput("busy cancel+start busy", {31'd0, busy}, 32'd0);
    checkOutput("busy cancel+start hi", hi, m_hi);
    @(negedge clk);
    checkOutput("busy cancel+start stays idle", {31'd0, busy}, 32'd0);

    $display("[TB] randomized ops");
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      runOp($sformatf("rand%0d op%0d", i, op), op, a, b, 1'b1, n);
    end

    $display("[TB] reset mid-divide");
    runOp("pre-reset mthi", OP_MTHI, 32'h1111_1111, 32'd0, 1'b0, n);
    runOp("pre-reset mtlo", OP_MTLO, 32'h2222_2222, 32'd0, 1'b0, n);
    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    checkOutput("async reset hi", hi, m_hi);
    checkOutput("async reset lo", lo, m_lo);
    checkOutput("async reset busy", {31'd0, busy}, 32'd0);
    checkOutput("async reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    checkOutput("post-reset no done", {31'd0, saw_done}, 32'd0);
    checkOutput("post-reset no busy", {31'd0, saw_busy}, 32'd0);
    checkOutput("post-reset hi", hi, m_hi);
    checkOutput("post-reset lo", lo, m_lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
